// File: rtl/risc5_mem_pkg.sv
// rtl/risc5_mem_pkg.sv - shared state type, lane decode and timing defaults for the RISC5 SRAM port
package risc5_mem_pkg;

  localparam int RD_WAIT_DEF = 2;
  localparam int WR_WAIT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACT   = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_RECOV = 3'd4,
    NULL_ACC = 3'd5
  } mem_state_t;

  // Active-low byte-lane enables for a write. Word writes enable all lanes.
  function automatic logic [3:0] lane_be_n(input logic ben, input logic [1:0] lane);
    if (ben) begin
      return ~(4'b0001 << lane);
    end
    return 4'h0;
  endfunction

endpackage

// File: rtl/risc5_sram_port.sv
// rtl/risc5_sram_port.sv - RISC5 data-bus responder running multi-cycle accesses to an async 32-bit SRAM
//   clk, rst (async, active-low)
//   CPU side : adr, rd, wr, ben, outbus -> inbus, stallX
//   SRAM side: sram_addr, sram_din, sram_dout, sram_drive, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
module risc5_sram_port
  import risc5_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 262144,
  parameter int AW          = 18,
  parameter int RD_WAIT     = RD_WAIT_DEF,
  parameter int WR_WAIT     = WR_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   adr,
  input  logic          rd,
  input  logic          wr,
  input  logic          ben,
  input  logic [31:0]   outbus,
  output logic [31:0]   inbus,
  output logic          stallX,
  output logic [AW-1:0] sram_addr,
  input  logic [31:0]   sram_din,
  output logic [31:0]   sram_dout,
  output logic          sram_drive,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [3:0]    sram_be_n
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

  mem_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          op_rd, op_rd_d;

  logic [31:0]   inbus_d;
  logic          stall_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   dout_d;
  logic          drive_d;
  logic          ce_n_d;
  logic          oe_n_d;
  logic          we_n_d;
  logic [3:0]    be_n_d;

  logic          req;
  logic          oor;
  logic          accept;
  logic          in_access_d;
  logic          in_write_d;

  assign req    = rd | wr;
  assign oor    = {10'd0, adr[23:2]} >= 32'(DEPTH_WORDS);
  // Only in-range requests touch the SRAM address/lane registers.
  assign accept = (state == IDLE) && req && !oor;

  // State and output registers: every CPU- and SRAM-facing signal is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_rd      <= 1'b0;
      inbus      <= '0;
      stallX     <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_drive <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      op_rd      <= op_rd_d;
      inbus      <= inbus_d;
      stallX     <= stall_d;
      sram_addr  <= addr_d;
      sram_dout  <= dout_d;
      sram_drive <= drive_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_be_n  <= be_n_d;
    end
  end

  // Next state and wait counter. The counter is loaded on entry to a
  // timed state and the state is left when it reads zero.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (oor) begin
            state_d = NULL_ACC;
          end else if (wr) begin
            state_d = WR_SETUP;
          end else begin
            state_d = RD_ACT;
            cnt_d   = RD_LOAD;
          end
        end
      end
      RD_ACT: begin
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          state_d = WR_RECOV;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      WR_RECOV: state_d = IDLE;
      NULL_ACC: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output next values are a function of the state being entered, so the
  // strobes change on the same edge as the state register.
  always_comb begin
    in_access_d = state_d inside {RD_ACT, WR_SETUP, WR_PULSE, WR_RECOV};
    in_write_d  = state_d inside {WR_SETUP, WR_PULSE, WR_RECOV};

    stall_d = (state_d != IDLE);
    ce_n_d  = !in_access_d;
    oe_n_d  = (state_d != RD_ACT);
    we_n_d  = (state_d != WR_PULSE);
    drive_d = in_write_d;

    addr_d  = sram_addr;
    dout_d  = sram_dout;
    be_n_d  = sram_be_n;
    op_rd_d = op_rd;
    inbus_d = inbus;

    if ((state == IDLE) && req) begin
      // Write wins when rd and wr arrive together.
      op_rd_d = !wr;
    end

    if (accept) begin
      addr_d = adr[AW+1:2];
      // Byte reads still fetch the full word; the CPU picks the lane.
      be_n_d = wr ? lane_be_n(ben, adr[1:0]) : 4'h0;
      if (wr) begin
        dout_d = outbus;
      end
    end else if (!in_access_d) begin
      be_n_d = 4'hF;
    end

    if ((state == RD_ACT) && (state_d == IDLE)) begin
      inbus_d = sram_din;
    end else if ((state == NULL_ACC) && op_rd) begin
      inbus_d = '0;
    end
  end

endmodule

// File: tb/tb_risc5_sram_port.sv
// tb/tb_risc5_sram_port.sv - self-checking bench for risc5_sram_port with SRAM model and transaction-level reference
module tb_risc5_sram_port;

  localparam int DEPTH   = 1024;
  localparam int AWB     = 10;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_NULL = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [23:0]    adr = '0;
  logic           rd = 1'b0;
  logic           wr = 1'b0;
  logic           ben = 1'b0;
  logic [31:0]    outbus = '0;
  logic [31:0]    inbus;
  logic           stallX;
  logic [AWB-1:0] sram_addr;
  logic [31:0]    sram_din;
  logic [31:0]    sram_dout;
  logic           sram_drive;
  logic           sram_ce_n;
  logic           sram_oe_n;
  logic           sram_we_n;
  logic [3:0]     sram_be_n;

  risc5_sram_port #(
    .DEPTH_WORDS(DEPTH),
    .AW(AWB),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .adr(adr),
    .rd(rd),
    .wr(wr),
    .ben(ben),
    .outbus(outbus),
    .inbus(inbus),
    .stallX(stallX),
    .sram_addr(sram_addr),
    .sram_din(sram_din),
    .sram_dout(sram_dout),
    .sram_drive(sram_drive),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Pin-level SRAM contents and the bench's expected contents.
  logic [31:0] sram_mem [0:DEPTH-1];
  logic [31:0] exp_mem  [0:DEPTH-1];
  bit          loaded = 0;

  assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 32'hFFFF_FFFF;

  // Reference: one transaction at a time, described by its kind, length in
  // stall cycles, target word, lanes and data.
  int          m_kind = 0;
  int          m_len = 0;
  int          m_left = 0;
  logic [21:0] m_word = '0;
  logic [3:0]  m_be = 4'hF;
  logic [31:0] m_data = '0;
  logic [31:0] m_inbus = '0;

  always @(posedge clk or negedge rst) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) begin
        sram_mem[i] = init_word(i);
        exp_mem[i]  = init_word(i);
      end
      loaded = 1;
    end
    if (!rst) begin
      m_kind  = 0;
      m_left  = 0;
      m_inbus = '0;
    end else if (clk) begin
      if (!sram_ce_n && !sram_we_n) begin
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) sram_mem[sram_addr][8*b +: 8] = sram_dout[8*b +: 8];
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_kind == K_RD) m_inbus = exp_mem[m_word[9:0]];
          else if (m_kind == K_NULL && !m_be[0]) m_inbus = '0;
          m_kind = 0;
        end
      end else if (rd || wr) begin
        m_word = adr[23:2];
        m_data = outbus;
        if (m_word >= 22'(DEPTH)) begin
          m_kind = K_NULL;
          m_len  = 1;
          m_be   = wr ? 4'hF : 4'h0;   // bit 0 low marks a dropped read
        end else if (wr) begin
          m_kind = K_WR;
          m_len  = WR_WAIT + 2;
          m_be   = 4'h0;
          if (ben) begin
            m_be = 4'hF;
            m_be[adr[1:0]] = 1'b0;
          end
          for (int b = 0; b < 4; b++)
            if (!m_be[b]) exp_mem[m_word[9:0]][8*b +: 8] = outbus[8*b +: 8];
        end else begin
          m_kind = K_RD;
          m_len  = RD_WAIT;
          m_be   = 4'h0;
        end
        m_left = m_len;
      end
    end
  end

  int stall_highs = 0;
  int oe_lows = 0;
  int we_lows = 0;
  int ce_lows = 0;

  always @(negedge clk) begin
    int idx;
    if (loaded) begin
      stall_highs += int'(stallX);
      oe_lows     += int'(!sram_oe_n);
      we_lows     += int'(!sram_we_n);
      ce_lows     += int'(!sram_ce_n);
      check("inbus", inbus, m_inbus);
      check("oe_we_overlap", {31'd0, sram_oe_n | sram_we_n}, 32'd1);
      if (m_left > 0) begin
        idx = m_len - m_left;
        check("stall_busy", {31'd0, stallX}, 32'd1);
        if (m_kind == K_RD) begin
          check("rd_ce_n", {31'd0, sram_ce_n}, 32'd0);
          check("rd_oe_n", {31'd0, sram_oe_n}, 32'd0);
          check("rd_we_n", {31'd0, sram_we_n}, 32'd1);
          check("rd_drive", {31'd0, sram_drive}, 32'd0);
          check("rd_addr", {22'd0, sram_addr}, {22'd0, m_word[9:0]});
          check("rd_be_n", {28'd0, sram_be_n}, 32'd0);
        end else if (m_kind == K_WR) begin
          check("wr_ce_n", {31'd0, sram_ce_n}, 32'd0);
          check("wr_oe_n", {31'd0, sram_oe_n}, 32'd1);
          check("wr_we_n", {31'd0, sram_we_n}, (idx >= 1 && idx <= WR_WAIT) ? 32'd0 : 32'd1);
          check("wr_drive", {31'd0, sram_drive}, 32'd1);
          check("wr_dout", sram_dout, m_data);
          check("wr_addr", {22'd0, sram_addr}, {22'd0, m_word[9:0]});
          check("wr_be_n", {28'd0, sram_be_n}, {28'd0, m_be});
        end else begin
          check("null_ce_n", {31'd0, sram_ce_n}, 32'd1);
          check("null_we_n", {31'd0, sram_we_n}, 32'd1);
          check("null_drive", {31'd0, sram_drive}, 32'd0);
        end
      end else begin
        check("idle_stall", {31'd0, stallX}, 32'd0);
        check("idle_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("idle_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
        check("idle_drive", {31'd0, sram_drive}, 32'd0);
      end
    end
  end

  // Called at posedge+1. Issues a one-cycle request once stallX is low.
  task automatic do_req(input logic r, input logic w, input logic b,
                        input logic [23:0] a, input logic [31:0] d);
    int guard = 0;
    while (stallX !== 1'b0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("req_timeout", 32'd1, 32'd0);
    rd = r; wr = w; ben = b; adr = a; outbus = d;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (stallX !== 1'b0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 32'd1, 32'd0);
  endtask

  int s0, o0, w0, c0, mism;
  logic [31:0] rd_val;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_stallX", {31'd0, stallX}, 32'd0);
    check("rst_inbus", inbus, 32'd0);
    check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check("rst_oe_we", {30'd0, sram_oe_n, sram_we_n}, 32'd3);
    check("rst_be_n", {28'd0, sram_be_n}, 32'hF);
    check("rst_addr", {22'd0, sram_addr}, 32'd0);
    check("rst_dout", sram_dout, 32'd0);
    check("rst_drive", {31'd0, sram_drive}, 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Word read of word 5.
    s0 = stall_highs; o0 = oe_lows;
    do_req(1'b1, 1'b0, 1'b0, 24'h000014, 32'h0);
    check("read5_addr", {22'd0, sram_addr}, 32'd5);
    check("read5_oe_n", {31'd0, sram_oe_n}, 32'd0);
    wait_idle();
    check("read5_stall_cycles", stall_highs - s0, 32'd2);
    check("read5_oe_cycles", oe_lows - o0, 32'd2);
    check("read5_inbus", inbus, 32'hDEADBEEF);

    // Byte write to lane 3 of word 8.
    s0 = stall_highs; w0 = we_lows;
    do_req(1'b0, 1'b1, 1'b1, 24'h000023, 32'hA5000000);
    check("bw_be_n", {28'd0, sram_be_n}, 32'h7);
    check("bw_addr", {22'd0, sram_addr}, 32'd8);
    wait_idle();
    check("bw_stall_cycles", stall_highs - s0, 32'd4);
    check("bw_we_cycles", we_lows - w0, 32'd2);
    check("bw_mem8", sram_mem[8], (init_word(8) & 32'h00FFFFFF) | 32'hA5000000);
    check("bw_inbus_kept", inbus, 32'hDEADBEEF);

    // Out-of-range read and write.
    s0 = stall_highs; c0 = ce_lows;
    do_req(1'b1, 1'b0, 1'b0, 24'h001000, 32'h0);
    wait_idle();
    check("oor_rd_stall", stall_highs - s0, 32'd1);
    check("oor_rd_ce", ce_lows - c0, 32'd0);
    check("oor_rd_inbus", inbus, 32'd0);
    w0 = we_lows; c0 = ce_lows;
    do_req(1'b0, 1'b1, 1'b0, 24'h001000, 32'h11223344);
    wait_idle();
    check("oor_wr_we", we_lows - w0, 32'd0);
    check("oor_wr_ce", ce_lows - c0, 32'd0);
    check("oor_wr_mem0", sram_mem[0], init_word(0));

    // Back-to-back write then read of the same word.
    do_req(1'b0, 1'b1, 1'b0, 24'h000040, 32'h12345678);
    do_req(1'b1, 1'b0, 1'b0, 24'h000040, 32'h0);
    wait_idle();
    check("b2b_inbus", inbus, 32'h12345678);

    // rd and wr together: write wins.
    o0 = oe_lows; w0 = we_lows;
    do_req(1'b1, 1'b1, 1'b0, 24'h000004, 32'h0000CAFE);
    wait_idle();
    check("both_we_cycles", we_lows - w0, 32'd2);
    check("both_oe_cycles", oe_lows - o0, 32'd0);
    check("both_inbus", inbus, 32'h12345678);
    check("both_mem1", sram_mem[1], 32'h0000CAFE);

    // Reset in the middle of a read.
    do_req(1'b1, 1'b0, 1'b0, 24'h000030, 32'h0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_stallX", {31'd0, stallX}, 32'd0);
    check("mid_rst_oe_ce", {30'd0, sram_oe_n, sram_ce_n}, 32'd3);
    check("mid_rst_inbus", inbus, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 1'b0, 24'h000010, 32'h0);
    wait_idle();
    check("post_rst_read", inbus, init_word(4));

    // Randomised traffic against the reference.
    for (int t = 0; t < 80; t++) begin
      int kind;
      logic [21:0] wd;
      kind = $urandom_range(0, 9);
      wd   = 22'($urandom_range(0, 1100));
      do_req(kind < 4 || kind == 9, kind >= 4, 1'($urandom_range(0, 1)),
             {wd, 2'($urandom_range(0, 3))}, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    @(posedge clk); #1;

    mism = 0;
    for (int i = 0; i < DEPTH; i++)
      if (sram_mem[i] !== exp_mem[i]) mism++;
    check("mem_final", mism, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/risc5_sram_port.md
Name: risc5_sram_port

Overview:
- Memory-side responder for the RISC5 data bus. It accepts rd/wr/ben/adr/outbus requests and returns read data on inbus.
- It paces the processor with stallX while it runs a multi-cycle access to an external asynchronous 32-bit SRAM.
- It sits between the CPU core and the board-level SRAM pins. Tri-state merging of the data pins is done at top level.

Parameters:
DEPTH_WORDS, 262144, number of 32-bit SRAM words; word index is adr[23:2]
AW, 18, SRAM word-address width (clog2 of DEPTH_WORDS)
RD_WAIT, 2, cycles oe_n/ce_n held low before read data is sampled (>=1)
WR_WAIT, 2, cycles we_n held low per write (>=1)

Ports:
clk  in  1  system clock, all flops on rising edge
rst  in  1  reset, asynchronous, active-low
adr  in  24  byte address from CPU
rd  in  1  read request (one-cycle pulse, already gated by CPU with ~stallX)
wr  in  1  write request (one-cycle pulse, gated likewise)
ben  in  1  byte access; lane = adr[1:0]
outbus  in  32  write data, already lane-positioned by CPU
inbus  out  32  read data, full word, registered
stallX  out  1  busy/stall to CPU, registered only
sram_addr  out  AW  SRAM word address
sram_din  in  32  data from SRAM pins
sram_dout  out  32  data to SRAM pins
sram_drive  out  1  1 = top level drives pins with sram_dout
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low
sram_be_n  out  4  byte-lane enables, active-low

Behaviour:
- stallX, inbus and all sram_* outputs come from flops only. There is no combinational path from rd/wr/adr to stallX, because the CPU gates rd/wr with ~stallX.
- Reset (rst=0, async):
  - state IDLE, stallX=0, inbus=0.
  - sram_ce_n=oe_n=we_n=1, be_n=4'hF, drive=0, addr=0, dout=0.
  - Reset mid-access aborts the access immediately with no completion.
- States: IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_RECOV, NULL_ACC.
- IDLE. Request cycle T0 = the cycle where rd or wr is sampled high. At the T0 edge:
  - Latch the address, data and lanes.
  - Set stallX=1 and go to the access state.
  - If rd and wr are both high, the write wins and the read is dropped.
- Range check: adr[23:2] >= DEPTH_WORDS is out of range.
  - Go to NULL_ACC: one stall cycle, no SRAM strobes.
  - A read returns inbus=0; a write is discarded.
- Read (RD_ACT): ce_n=oe_n=0 and be_n=0 for RD_WAIT cycles, starting T1.
  - On the edge ending the last wait cycle: capture sram_din into inbus, deassert stallX, return to IDLE.
  - stallX is high for exactly RD_WAIT cycles; inbus is valid from the first cycle stallX=0.
- Write: sram_dout=outbus and drive=1 from T1 through WR_RECOV.
  - WR_SETUP: 1 cycle, ce_n=0, we_n=1.
  - WR_PULSE: WR_WAIT cycles, we_n=0.
  - WR_RECOV: 1 cycle, we_n=1, ce_n=0.
  - Then IDLE with stallX=0. stallX is high for WR_WAIT+2 cycles.
- Lanes:
  - Word access (ben=0): be_n=4'h0.
  - Byte write: be_n = ~(4'b0001 << adr[1:0]).
  - Byte read: be_n=4'h0, full word returned; the CPU extracts the lane.
- inbus holds its value until the next completed read. Writes do not alter it.
- rd/wr seen while not IDLE are ignored; the CPU cannot legally issue them.
- Wait counter width is clog2(max(RD_WAIT,WR_WAIT)+1). It is loaded on state entry and counts down to 0.
- Back-to-back requests: a new request is accepted in the first cycle after stallX falls.

Decomposition:
- Shared package risc5_mem_pkg holds:
  - state enum;
  - lane-enable function (ben, adr[1:0] -> be_n);
  - default timing constants RD_WAIT_DEF and WR_WAIT_DEF.
- No sub-module: the FSM, the counter and the lane decode stay in one module.

Test Plan:
- Reset mid-read: async rst low during RD_ACT -> same instant ce_n=oe_n=1, stallX=0, inbus=0; after release a fresh read at 0x000010 completes normally.
- Word read, RD_WAIT=2, SRAM model word 5 = 0xDEADBEEF, rd pulse at adr=0x000014:
  - stallX=1 for 2 cycles; sram_addr=5, oe_n=0 in both.
  - inbus=0xDEADBEEF in the first cycle stallX=0.
- Byte write, ben=1, adr=0x000023, outbus=0xA5000000, WR_WAIT=2:
  - be_n=4'b0111; we_n low exactly 2 cycles at sram_addr=8; stallX high 4 cycles.
  - Model word 8 changes only in byte 3.
- Out-of-range, DEPTH_WORDS=1024: read at adr=0x001000 -> one stall cycle, no ce_n pulse, inbus=0; write at the same address -> no we_n pulse, memory unchanged.
- Back-to-back write then read of adr=0x000040, data 0x12345678 -> read accepted the cycle after stallX falls; inbus=0x12345678; no cycle where oe_n and we_n are both 0.
- Simultaneous rd=wr=1 at adr=0x000004, outbus=0x0000CAFE -> write performed (we_n pulses), no oe_n pulse, inbus unchanged.
